// File: rtl/csr_master_bridge_pkg.sv
// Shared definitions for the Wishbone-to-CSR master bridge: FSM encoding and address fields.
// Latency: none (types and constants only).
// Backpressure: none.
package csr_master_bridge_pkg;

  // Bridge FSM encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT1 = 2'd1,
    WAIT2 = 2'd2,
    ACK   = 2'd3
  } state_e;

  // CSR word address width.
  localparam int CSR_AW = 15;

  // Wishbone byte-address bits that form the CSR word address.
  localparam int WB_ADR_HI = 16;
  localparam int WB_ADR_LO = 2;

  // Slave-select field inside the CSR word address.
  localparam int CSR_SEL_HI = 14;
  localparam int CSR_SEL_LO = 10;

  typedef logic [CSR_AW-1:0] csr_addr_t;

endpackage

// File: rtl/csr_master_bridge_if.sv
// Bundle of the Wishbone slave port and the CSR master port of the bridge.
// Latency: none (wiring only).
// Backpressure: none; Wishbone side is throttled by wb_ack_o, CSR side has none.
interface csr_master_bridge_if;
  import csr_master_bridge_pkg::*;

  // Wishbone classic side
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic        wb_ack_o;

  // CSR bus side
  csr_addr_t   csr_a;
  logic        csr_we;
  logic [31:0] csr_do;
  logic [31:0] csr_di;

  // The bridge: Wishbone target, CSR initiator.
  modport master (
    input  wb_adr_i, wb_dat_i, wb_cyc_i, wb_stb_i, wb_we_i, csr_di,
    output wb_dat_o, wb_ack_o, csr_a, csr_we, csr_do
  );

  // The environment: Wishbone initiator plus the ORed CSR slaves.
  modport slave (
    output wb_adr_i, wb_dat_i, wb_cyc_i, wb_stb_i, wb_we_i, csr_di,
    input  wb_dat_o, wb_ack_o, csr_a, csr_we, csr_do
  );

endinterface

// File: rtl/csr_master_bridge.sv
// Wishbone classic slave to CSR bus master; one CSR access per Wishbone strobe.
// Latency: write ack 1 cycle after strobe accept, read ack 3 cycles after (CSR read latency is 1).
// Backpressure: strobes are only sampled in IDLE; the Wishbone master waits for wb_ack_o.
module csr_master_bridge
  import csr_master_bridge_pkg::*;
(
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  csr_master_bridge_if.master bus
);

  state_e      state_q, state_d;
  csr_addr_t   csr_a_q, csr_a_d;
  logic [31:0] csr_do_q, csr_do_d;
  logic        csr_we_q, csr_we_d;
  logic [31:0] wb_dat_q, wb_dat_d;
  logic        wb_ack_q, wb_ack_d;

  // Address bits outside the word-address slice carry no meaning here.
  logic unused_adr_bits;
  assign unused_adr_bits = ^{bus.wb_adr_i[31:WB_ADR_HI+1], bus.wb_adr_i[WB_ADR_LO-1:0]};

  // Next-state and output logic; every output is registered so no input reaches an output combinationally.
  always_comb begin
    state_d  = state_q;
    csr_a_d  = csr_a_q;
    csr_do_d = csr_do_q;
    csr_we_d = 1'b0;
    wb_dat_d = wb_dat_q;
    wb_ack_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.wb_cyc_i && bus.wb_stb_i) begin
          csr_a_d  = bus.wb_adr_i[WB_ADR_HI:WB_ADR_LO];
          csr_do_d = bus.wb_dat_i;
          csr_we_d = bus.wb_we_i;
          if (bus.wb_we_i) begin
            // Write completes as soon as the strobe reaches the slaves.
            state_d  = ACK;
            wb_ack_d = 1'b1;
          end else begin
            state_d  = WAIT1;
          end
        end
      end
      // Slaves register csr_di from csr_a during this cycle.
      WAIT1: state_d = WAIT2;
      WAIT2: begin
        state_d  = ACK;
        wb_dat_d = bus.csr_di;
        wb_ack_d = 1'b1;
      end
      // Ack cycle ignores the strobe so the master can retire it.
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= IDLE;
      csr_a_q  <= '0;
      csr_do_q <= '0;
      csr_we_q <= 1'b0;
      wb_dat_q <= '0;
      wb_ack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      csr_a_q  <= csr_a_d;
      csr_do_q <= csr_do_d;
      csr_we_q <= csr_we_d;
      wb_dat_q <= wb_dat_d;
      wb_ack_q <= wb_ack_d;
    end
  end

  assign bus.csr_a    = csr_a_q;
  assign bus.csr_do   = csr_do_q;
  assign bus.csr_we   = csr_we_q;
  assign bus.wb_dat_o = wb_dat_q;
  assign bus.wb_ack_o = wb_ack_q;

endmodule

// File: doc/csr_master_bridge.md
CSR_MASTER_BRIDGE -- requirements
Module: csr_master_bridge

Interface
REQ-001 SHALL have no parameters; CSR read latency is fixed at 1 cycle (slave registers csr_do one edge after csr_a).
REQ-002 sys_clk  in  1  sole clock; all state on rising edge.
REQ-003 sys_rst_n  in  1  reset; one clock, asynchronous, active-low.
REQ-004 wb_adr_i  in  32  Wishbone byte address; bits [16:2] used.
REQ-005 wb_dat_i  in  32  Wishbone write data.
REQ-006 wb_dat_o  out  32  Wishbone read data, registered.
REQ-007 wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone classic cycle, strobe, write.
REQ-008 wb_ack_o  out  1  Wishbone acknowledge, registered, single-cycle pulse.
REQ-009 csr_a  out  15  CSR word address to all slaves; bits [14:10] select the slave.
REQ-010 csr_we  out  1  CSR write strobe, single-cycle pulse.
REQ-011 csr_do  out  32  CSR write data to slaves.
REQ-012 csr_di  in  32  OR of all slave read buses; non-selected slaves drive zero.

Function
REQ-013 FSM states: IDLE, WAIT1, WAIT2, ACK.
REQ-014 IDLE and wb_cyc_i & wb_stb_i sampled high at edge T0: csr_a <= wb_adr_i[16:2], csr_do <= wb_dat_i, csr_we <= wb_we_i.
REQ-015 Write: next state ACK; csr_a/csr_do/csr_we valid in cycle T0+1; wb_ack_o high in cycle T0+1 only.
REQ-016 Read: IDLE->WAIT1->WAIT2->ACK; csr_we stays 0.
REQ-017 Read: wb_dat_o <= csr_di at the edge leaving WAIT2; wb_ack_o high in cycle T0+3 only, with wb_dat_o valid.
REQ-018 csr_we SHALL be high for exactly one cycle per write, never during reads or in IDLE.
REQ-019 ACK SHALL always return to IDLE; a strobe present in the ACK cycle SHALL NOT start a transaction.
REQ-020 Back-to-back: a strobe sampled in IDLE on the cycle after ACK SHALL start a new transaction; sustained throughput 1 write / 2 cycles, 1 read / 4 cycles.
REQ-021 csr_a and csr_do SHALL hold their last values outside transactions; only csr_we returns to 0.
REQ-022 wb_dat_o SHALL change only on read completion and otherwise hold its last value.
REQ-023 wb_cyc_i or wb_stb_i dropping mid-transaction SHALL NOT abort it: the CSR access completes and the ack pulse is still issued.
REQ-024 wb_adr_i bits [31:17] and [1:0] are ignored; byte selects are not ports, and all accesses are full 32-bit.
REQ-025 No combinational path from any input to any output.

Reset
REQ-026 sys_rst_n low SHALL immediately force IDLE, csr_a=0, csr_we=0, csr_do=0, wb_dat_o=0, wb_ack_o=0.
REQ-027 Reset mid-transaction SHALL drop it with no ack and no further csr_we.
REQ-028 The first transaction SHALL be accepted at the first rising edge after deassertion with the strobe high.

Structure
REQ-029 Shared package SHALL hold the FSM state encoding, the CSR address width (15), the Wishbone address slice bounds (16:2), and the slave-select field (14:10).
REQ-030 Single flat module; no sub-module.

Verification
REQ-031 Write 0xDEADBEEF to byte address 0x0000_0004 -> csr_a=0x0001, csr_do=0xDEADBEEF, csr_we=1 for one cycle at T0+1, wb_ack_o at T0+1.
REQ-032 Read byte address 0x0000_1000 with a model slave returning 0x1234_5678 one cycle after csr_a -> csr_a=0x0400, csr_we never high, wb_ack_o at T0+3, wb_dat_o=0x12345678.
REQ-033 Write followed immediately by a read, strobe held continuously -> exactly one csr_we pulse, two ack pulses at T0+1 and T0+5, ack never on consecutive cycles.
REQ-034 Read with strobe dropped after T0 -> ack still at T0+3, FSM in IDLE at T0+4, no spurious second transaction.
REQ-035 sys_rst_n pulsed low mid-cycle while in WAIT1 -> outputs zero asynchronously, no ack, next strobe after release serviced normally.
REQ-036 Random mixed stream of 1000 transactions vs. a scoreboard slave model -> all reads match, every write lands once, one ack per strobe.
